iters_write_queue: RTL

ITERS_WRITE_QUEUE -- requirements
Module: iters_write_queue

---
 rtl/gpu_pkg.sv | 44 ++++
 rtl/sync_fifo.sv | 87 ++++++++
 rtl/iters_write_queue.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
// Shared definitions for the iteration-count write path into the frame buffer.
//   FMA_COUNT   : pixels carried per write word
//   ITERS_BITS  : iteration-count width per pixel
//   WIDTH/HEIGHT: frame dimensions, ADDR_BITS derived from their product
//   queue_entry_t : one write-queue entry {swap_after, has_write, iters, addr}
//   wq_state_t    : drain FSM states
//   sat_inc16     : saturating 16-bit increment used by the statistics counters
// -----------------------------------------------------------------------------
package gpu_pkg;

    localparam int FMA_COUNT  = 2;
    localparam int ITERS_BITS = 4;
    localparam int WIDTH      = 320;
    localparam int HEIGHT     = 160;
    localparam int ADDR_BITS  = $clog2(WIDTH * HEIGHT);

    // Entry layout for the default configuration; the queue rebuilds the same
    // layout locally from its own parameters so overrides stay consistent.
    typedef struct packed {
        logic                              swap_after;
        logic                              has_write;
        logic [ITERS_BITS*FMA_COUNT-1:0]   iters;
        logic [ADDR_BITS-1:0]              addr;
    } queue_entry_t;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_SWAP = 1'b1
    } wq_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with occupancy count. A write while full is accepted only
// when a read happens in the same cycle; a read while empty is ignored.
// Ports:
//   clk_in, rst_in (sync, active-high)
//   wr_en_in / wr_data_in   : push request and data
//   rd_en_in / rd_data_out  : pop request, head data (valid when not empty)
//   full_out, empty_out, count_out : status, count_out is occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          wr_en_in,
    input  logic [DW-1:0] wr_data_in,
    input  logic          rd_en_in,
    output logic [DW-1:0] rd_data_out,
    output logic          full_out,
    output logic          empty_out,
    output logic [CW-1:0] count_out
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_wr_s;
    logic          do_rd_s;

    // Accept/advance decisions and next pointer/count values.
    always_comb begin
        do_rd_s  = rd_en_in && (count_q != {CW{1'b0}});
        do_wr_s  = wr_en_in && ((count_q != FULL_CNT) || do_rd_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_wr_s, do_rd_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while the count says empty.
    always_ff @(posedge clk_in) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q] <= wr_data_in;
        end
    end

    assign rd_data_out = mem_q[rd_ptr_q];
    assign full_out    = (count_q == FULL_CNT);
    assign empty_out   = (count_q == {CW{1'b0}});
    assign count_out   = count_q;

endmodule

// File: rtl/iters_write_queue.sv
// -----------------------------------------------------------------------------
// iters_write_queue
// Buffers iteration-count write words and frame-complete markers, and drains
// them to the frame buffer so that a swap is never emitted before the writes
// that precede it, nor after the writes that follow it.
// Ports:
//   clk_in, rst_in            : clock, synchronous active-high reset
//   iters_valid_in/iters_in/addr_in : write word offered this cycle
//   swap_in                   : frame-complete pulse (may coincide with a word)
//   fb_ready_in               : frame buffer accepts a write this cycle
//   iters_valid_out/iters_out/addr_out : registered frame-buffer write
//   swap_out                  : registered one-cycle swap pulse
//   full_out, overflow_out (sticky), count_out : queue status
//   drop_count_out, frame_count_out : statistics (zero unless enabled)
// Build option: define ITERS_QUEUE_STATS_EN to build the saturating
// dropped-push and emitted-swap counters.
// -----------------------------------------------------------------------------
module iters_write_queue #(
    parameter  int FMA_COUNT  = gpu_pkg::FMA_COUNT,
    parameter  int ITERS_BITS = gpu_pkg::ITERS_BITS,
    parameter  int WIDTH      = gpu_pkg::WIDTH,
    parameter  int HEIGHT     = gpu_pkg::HEIGHT,
    parameter  int DEPTH      = 16,
    localparam int AW         = $clog2(WIDTH * HEIGHT),
    localparam int IW         = ITERS_BITS * FMA_COUNT,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          iters_valid_in,
    input  logic [IW-1:0] iters_in,
    input  logic [AW-1:0] addr_in,
    input  logic          swap_in,
    input  logic          fb_ready_in,
    output logic          iters_valid_out,
    output logic [IW-1:0] iters_out,
    output logic [AW-1:0] addr_out,
    output logic          swap_out,
    output logic          full_out,
    output logic          overflow_out,
    output logic [CW-1:0] count_out,
    output logic [15:0]   drop_count_out,
    output logic [15:0]   frame_count_out
);

    import gpu_pkg::*;

    typedef struct packed {
        logic          swap_after;
        logic          has_write;
        logic [IW-1:0] iters;
        logic [AW-1:0] addr;
    } entry_t;

    localparam int EW = $bits(entry_t);

    entry_t        push_entry_s;
    entry_t        head_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;

    wq_state_t     state_q, state_d;
    logic          iters_valid_q, iters_valid_d;
    logic [IW-1:0] iters_q, iters_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          swap_q, swap_d;
    logic          overflow_q, overflow_d;

    // Build the entry to enqueue; a bare swap becomes a marker with no write.
    always_comb begin
        push_entry_s            = '0;
        push_entry_s.swap_after = swap_in;
        push_entry_s.has_write  = iters_valid_in;
        if (iters_valid_in) begin
            push_entry_s.iters = iters_in;
            push_entry_s.addr  = addr_in;
        end else begin
            push_entry_s.iters = {IW{1'b0}};
            push_entry_s.addr  = {AW{1'b0}};
        end
        push_s = iters_valid_in || swap_in;
    end

    // Pop only while running; SWAP holds the head so the swap pulse is
    // cleanly separated from both neighbouring writes.
    always_comb begin
        pop_s  = (state_q == ST_RUN) && !empty_s && fb_ready_in;
        drop_s = push_s && full_s && !pop_s;
    end

    sync_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .wr_en_in    (push_s),
        .wr_data_in  (push_entry_s),
        .rd_en_in    (pop_s),
        .rd_data_out (head_s),
        .full_out    (full_s),
        .empty_out   (empty_s),
        .count_out   (count_s)
    );

    // Next state and next registered outputs of the drain FSM.
    always_comb begin
        state_d       = state_q;
        iters_valid_d = 1'b0;
        iters_d       = {IW{1'b0}};
        addr_d        = {AW{1'b0}};
        swap_d        = 1'b0;
        overflow_d    = overflow_q || drop_s;
        case (state_q)
            ST_RUN: begin
                if (pop_s) begin
                    iters_valid_d = head_s.has_write;
                    if (head_s.has_write) begin
                        iters_d = head_s.iters;
                        addr_d  = head_s.addr;
                    end else begin
                        iters_d = {IW{1'b0}};
                        addr_d  = {AW{1'b0}};
                    end
                    if (head_s.swap_after) begin
                        state_d = ST_SWAP;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SWAP: begin
                swap_d  = 1'b1;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= ST_RUN;
            iters_valid_q <= 1'b0;
            iters_q       <= {IW{1'b0}};
            addr_q        <= {AW{1'b0}};
            swap_q        <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            iters_valid_q <= iters_valid_d;
            iters_q       <= iters_d;
            addr_q        <= addr_d;
            swap_q        <= swap_d;
            overflow_q    <= overflow_d;
        end
    end

    assign iters_valid_out = iters_valid_q;
    assign iters_out       = iters_q;
    assign addr_out        = addr_q;
    assign swap_out        = swap_q;
    assign overflow_out    = overflow_q;
    assign full_out        = full_s;
    assign count_out       = count_s;

`ifdef ITERS_QUEUE_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Frame counter advances on the same edge that raises swap_out.
    always_comb begin
        if (drop_s) begin
            drop_cnt_d = sat_inc16(drop_cnt_q);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
        if (swap_d) begin
            frame_cnt_d = sat_inc16(frame_cnt_q);
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            drop_cnt_q  <= 16'h0000;
            frame_cnt_q <= 16'h0000;
        end else begin
            drop_cnt_q  <= drop_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign drop_count_out  = drop_cnt_q;
    assign frame_count_out = frame_cnt_q;
`else
    assign drop_count_out  = 16'h0000;
    assign frame_count_out = 16'h0000;
`endif

endmodule
